// File: rtl/object_tracking_pkg.sv
// Shared definitions for the object tracking path (delta mask, locator, overlay).
package object_tracking_pkg;

  localparam int unsigned DefDispWidth  = 11;
  localparam int unsigned DefInputWidth = 10;

  typedef enum logic [1:0] {
    StSync   = 2'd0,
    StAccum  = 2'd1,
    StReport = 2'd2
  } loc_state_e;

endpackage

// File: rtl/pix_align_delay.sv
// Fixed-depth register line that aligns position/qualifier with the delayed mask.
module pix_align_delay #(
  parameter int unsigned Width = 23,
  parameter int unsigned Depth = 1
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout
);

  if (Depth == 0) begin : g_bypass
    assign dout = din;
  end else begin : g_pipe
    logic [Width-1:0] pipe_q [Depth];

    always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
        for (int i = 0; i < Depth; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= din;
        for (int i = 1; i < Depth; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign dout = pipe_q[Depth-1];
  end

endmodule

// File: rtl/object_locator.sv
// Locates the moving object in each delta-mask frame as a bounding box and
// publishes one registered result per frame.
module object_locator
  import object_tracking_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH = DefInputWidth,
  parameter int unsigned DISP_WIDTH  = DefDispWidth,
  parameter int unsigned PIX_DELAY   = 1,
  parameter int unsigned MIN_RUN     = 4,
  parameter int unsigned MIN_PIXELS  = 64,
  parameter int unsigned CNT_WIDTH   = 20
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   enable,
  input  logic                   is_not_blank,
  input  logic [DISP_WIDTH-1:0]  x_pos,
  input  logic [DISP_WIDTH-1:0]  y_pos,
  input  logic                   frame_end,
  input  logic [INPUT_WIDTH-1:0] delta_frame,
  output logic                   obj_found,
  output logic [DISP_WIDTH-1:0]  x_min,
  output logic [DISP_WIDTH-1:0]  x_max,
  output logic [DISP_WIDTH-1:0]  y_min,
  output logic [DISP_WIDTH-1:0]  y_max,
  output logic [DISP_WIDTH-1:0]  x_center,
  output logic [DISP_WIDTH-1:0]  y_center,
  output logic [CNT_WIDTH-1:0]   pix_count,
  output logic                   result_valid
);

  localparam int unsigned AlignW = 2 * DISP_WIDTH + 1;
  localparam logic [3:0] MinRun = 4'(MIN_RUN);
  localparam logic [CNT_WIDTH:0] RunCredit = (CNT_WIDTH+1)'(MIN_RUN);
  localparam logic [CNT_WIDTH:0] OneCredit = (CNT_WIDTH+1)'(1);
  localparam logic [CNT_WIDTH-1:0] MinPixels = CNT_WIDTH'(MIN_PIXELS);

  logic [AlignW-1:0]     align_bus;
  logic                  al_active;
  logic [DISP_WIDTH-1:0] al_x, al_y;

  pix_align_delay #(
    .Width (AlignW),
    .Depth (PIX_DELAY)
  ) u_align (
    .clk     (clk),
    .aresetn (aresetn),
    .din     ({is_not_blank, y_pos, x_pos}),
    .dout    (align_bus)
  );

  assign al_active = align_bus[AlignW-1];
  assign al_y      = align_bus[2*DISP_WIDTH-1:DISP_WIDTH];
  assign al_x      = align_bus[DISP_WIDTH-1:0];

  // The mask is all-ones or all-zeros, so only the MSB carries information.
  logic unused_mask_lsbs;
  assign unused_mask_lsbs = ^delta_frame[INPUT_WIDTH-2:0];

  logic                  pixel_on, run_begin, qualified, first_qual;
  logic [3:0]            run_cnt_q, run_cnt_d, run_base;
  logic [DISP_WIDTH-1:0] run_start_q, run_x0;

  // A new line restarts the run even when the video stays active across the wrap.
  always_comb begin
    pixel_on   = al_active & delta_frame[INPUT_WIDTH-1];
    run_base   = (al_x == '0) ? 4'd0 : run_cnt_q;
    run_begin  = pixel_on && (run_base == 4'd0);
    run_x0     = run_begin ? al_x : run_start_q;
    run_cnt_d  = '0;
    if (pixel_on) run_cnt_d = (run_base >= MinRun) ? MinRun : run_base + 4'd1;
    qualified  = pixel_on && (run_cnt_d >= MinRun);
    first_qual = qualified && (run_base < MinRun);
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      run_cnt_q   <= '0;
      run_start_q <= '0;
    end else begin
      run_cnt_q   <= run_cnt_d;
      run_start_q <= run_x0;
    end
  end

  loc_state_e state_q, state_d;
  logic       acc_clear, acc_update, report;

  always_comb begin
    state_d    = state_q;
    acc_clear  = 1'b0;
    acc_update = 1'b0;
    report     = 1'b0;
    unique case (state_q)
      StSync: begin
        acc_clear = 1'b1;
        if (frame_end && enable) state_d = StAccum;
      end
      StAccum: begin
        if (!enable) begin
          acc_clear = 1'b1;
          state_d   = StSync;
        end else if (frame_end) begin
          state_d = StReport;
        end else begin
          acc_update = qualified;
        end
      end
      StReport: begin
        report    = 1'b1;
        acc_clear = 1'b1;
        state_d   = enable ? StAccum : StSync;
      end
      default: state_d = StSync;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state_q <= StSync;
    else          state_q <= state_d;
  end

  logic [DISP_WIDTH-1:0] acc_xmin_q, acc_xmax_q, acc_ymin_q, acc_ymax_q;
  logic [CNT_WIDTH-1:0]  acc_cnt_q;
  logic [CNT_WIDTH:0]    acc_sum;

  // The first qualified pixel credits the whole run that led up to it.
  assign acc_sum = {1'b0, acc_cnt_q} + (first_qual ? RunCredit : OneCredit);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      acc_xmin_q <= '1;
      acc_ymin_q <= '1;
      acc_xmax_q <= '0;
      acc_ymax_q <= '0;
      acc_cnt_q  <= '0;
    end else if (acc_clear) begin
      acc_xmin_q <= '1;
      acc_ymin_q <= '1;
      acc_xmax_q <= '0;
      acc_ymax_q <= '0;
      acc_cnt_q  <= '0;
    end else if (acc_update) begin
      if (first_qual && (run_x0 < acc_xmin_q)) acc_xmin_q <= run_x0;
      if (al_x > acc_xmax_q) acc_xmax_q <= al_x;
      if (al_y < acc_ymin_q) acc_ymin_q <= al_y;
      if (al_y > acc_ymax_q) acc_ymax_q <= al_y;
      acc_cnt_q <= acc_sum[CNT_WIDTH] ? '1 : acc_sum[CNT_WIDTH-1:0];
    end
  end

  logic [DISP_WIDTH:0] x_sum, y_sum;
  assign x_sum = {1'b0, acc_xmin_q} + {1'b0, acc_xmax_q};
  assign y_sum = {1'b0, acc_ymin_q} + {1'b0, acc_ymax_q};

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      obj_found    <= 1'b0;
      x_min        <= '0;
      x_max        <= '0;
      y_min        <= '0;
      y_max        <= '0;
      x_center     <= '0;
      y_center     <= '0;
      pix_count    <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= report;
      if (report) begin
        pix_count <= acc_cnt_q;
        obj_found <= (acc_cnt_q >= MinPixels);
        if (acc_cnt_q >= MinPixels) begin
          x_min    <= acc_xmin_q;
          x_max    <= acc_xmax_q;
          y_min    <= acc_ymin_q;
          y_max    <= acc_ymax_q;
          x_center <= x_sum[DISP_WIDTH:1];
          y_center <= y_sum[DISP_WIDTH:1];
        end
      end
    end
  end

endmodule

// File: tb/tb_object_locator.sv
// Directed and randomized frames driven into two locator configurations,
// checked against a run-length reference model of the mask image.
module tb_object_locator;

  localparam int DW = 11;
  localparam int IW = 10;
  localparam int CW = 20;
  localparam int MinPix = 64;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic enable = 1'b1;
  logic is_not_blank = 1'b0;
  logic frame_end = 1'b0;
  logic [DW-1:0] x_pos = '0;
  logic [DW-1:0] y_pos = '0;
  logic [IW-1:0] delta_d [2];

  logic          found_o [2];
  logic          rv_o    [2];
  logic [DW-1:0] xmin_o  [2];
  logic [DW-1:0] xmax_o  [2];
  logic [DW-1:0] ymin_o  [2];
  logic [DW-1:0] ymax_o  [2];
  logic [DW-1:0] xc_o    [2];
  logic [DW-1:0] yc_o    [2];
  logic [CW-1:0] pix_o   [2];

  always #5 clk = ~clk;

  // Unit 0: default settings. Unit 1: three-clock mask lag, no run filter.
  object_locator #(
    .INPUT_WIDTH (IW), .DISP_WIDTH (DW), .PIX_DELAY (1),
    .MIN_RUN (4), .MIN_PIXELS (MinPix), .CNT_WIDTH (CW)
  ) u_dut0 (
    .clk (clk), .aresetn (aresetn), .enable (enable), .is_not_blank (is_not_blank),
    .x_pos (x_pos), .y_pos (y_pos), .frame_end (frame_end), .delta_frame (delta_d[0]),
    .obj_found (found_o[0]), .x_min (xmin_o[0]), .x_max (xmax_o[0]), .y_min (ymin_o[0]),
    .y_max (ymax_o[0]), .x_center (xc_o[0]), .y_center (yc_o[0]), .pix_count (pix_o[0]),
    .result_valid (rv_o[0])
  );

  object_locator #(
    .INPUT_WIDTH (IW), .DISP_WIDTH (DW), .PIX_DELAY (3),
    .MIN_RUN (1), .MIN_PIXELS (MinPix), .CNT_WIDTH (CW)
  ) u_dut1 (
    .clk (clk), .aresetn (aresetn), .enable (enable), .is_not_blank (is_not_blank),
    .x_pos (x_pos), .y_pos (y_pos), .frame_end (frame_end), .delta_frame (delta_d[1]),
    .obj_found (found_o[1]), .x_min (xmin_o[1]), .x_max (xmax_o[1]), .y_min (ymin_o[1]),
    .y_max (ymax_o[1]), .x_center (xc_o[1]), .y_center (yc_o[1]), .pix_count (pix_o[1]),
    .result_valid (rv_o[1])
  );

  int tests = 0;
  int fails = 0;
  int n_rv [2] = '{0, 0};
  int n_rv_exp = 0;
  int min_run [2] = '{4, 1};

  // Expected published state per unit (box holds when no object is found).
  int e_found [2], e_cnt [2], e_xmin [2], e_xmax [2], e_ymin [2], e_ymax [2];

  bit img [0:15][0:639];
  int g_xlast, g_hblank, g_y0, g_lines;
  bit [7:0] hist = '0;
  bit synced = 1'b0;

  always @(posedge clk) begin
    if (rv_o[0] === 1'b1) n_rv[0]++;
    if (rv_o[1] === 1'b1) n_rv[1]++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic blank, input int x, input int y, input bit m, input logic fe);
    @(posedge clk);
    #1;
    hist = {hist[6:0], m};
    is_not_blank = blank;
    x_pos = DW'(x);
    y_pos = DW'(y);
    frame_end = fe;
    delta_d[0] = hist[1] ? '1 : '0;
    delta_d[1] = hist[3] ? '1 : '0;
  endtask

  task automatic clear_img();
    for (int r = 0; r < 16; r++)
      for (int x = 0; x < 640; x++) img[r][x] = 1'b0;
  endtask

  task automatic paint(input int x0, input int x1, input int r0, input int r1);
    for (int r = r0; r <= r1; r++)
      for (int x = x0; x <= x1; x++) img[r][x] = 1'b1;
  endtask

  task automatic geom(input int xlast, input int hblank, input int y0, input int lines);
    g_xlast = xlast; g_hblank = hblank; g_y0 = y0; g_lines = lines;
  endtask

  // Reference: every maximal horizontal run of length >= mr contributes all its pixels.
  function automatic void model(input int mr, output int cnt, output int xmn, output int xmx,
                                output int ymn, output int ymx);
    cnt = 0; xmn = 2047; xmx = 0; ymn = 2047; ymx = 0;
    for (int r = 0; r < g_lines; r++) begin
      for (int x = 0; x <= g_xlast; x++) begin
        if (img[r][x] && (x == 0 || !img[r][x-1])) begin
          int e = x;
          while (e < g_xlast && img[r][e+1]) e++;
          if (e - x + 1 >= mr) begin
            cnt += e - x + 1;
            if (x < xmn) xmn = x;
            if (e > xmx) xmx = e;
            if (g_y0 + r < ymn) ymn = g_y0 + r;
            if (g_y0 + r > ymx) ymx = g_y0 + r;
          end
        end
      end
    end
  endfunction

  task automatic run_frame(input int drop_at, input int rise_at);
    int cyc = 0;
    bit dropped = 1'b0;
    bit rep;
    int cnt, xmn, xmx, ymn, ymx;
    for (int r = 0; r < g_lines; r++) begin
      for (int x = 0; x <= g_xlast; x++) begin
        drive(1'b1, x, g_y0 + r, img[r][x], 1'b0);
        cyc++;
        if (cyc == drop_at) begin enable = 1'b0; dropped = 1'b1; end
        if (cyc == rise_at) enable = 1'b1;
      end
      for (int h = 0; h < g_hblank; h++) drive(1'b0, g_xlast, g_y0 + r, 1'b0, 1'b0);
    end
    for (int h = 0; h < 6; h++) drive(1'b0, 0, g_y0 + g_lines, 1'b0, 1'b0);
    if (dropped) synced = 1'b0;
    rep = synced && enable;
    if (enable) synced = 1'b1;
    if (rep) n_rv_exp++;
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("u%0d result_valid", d), 32'(rv_o[d]), 32'(rep));
      if (rep) begin
        model(min_run[d], cnt, xmn, xmx, ymn, ymx);
        e_cnt[d] = cnt;
        e_found[d] = (cnt >= MinPix) ? 1 : 0;
        if (cnt >= MinPix) begin
          e_xmin[d] = xmn; e_xmax[d] = xmx; e_ymin[d] = ymn; e_ymax[d] = ymx;
        end
      end
      chk($sformatf("u%0d pix_count", d), 32'(pix_o[d]), 32'(e_cnt[d]));
      chk($sformatf("u%0d obj_found", d), 32'(found_o[d]), 32'(e_found[d]));
      chk($sformatf("u%0d x_min", d), 32'(xmin_o[d]), 32'(e_xmin[d]));
      chk($sformatf("u%0d x_max", d), 32'(xmax_o[d]), 32'(e_xmax[d]));
      chk($sformatf("u%0d y_min", d), 32'(ymin_o[d]), 32'(e_ymin[d]));
      chk($sformatf("u%0d y_max", d), 32'(ymax_o[d]), 32'(e_ymax[d]));
      chk($sformatf("u%0d x_center", d), 32'(xc_o[d]), 32'((e_xmin[d] + e_xmax[d]) / 2));
      chk($sformatf("u%0d y_center", d), 32'(yc_o[d]), 32'((e_ymin[d] + e_ymax[d]) / 2));
    end
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    chk("u0 result_valid pulse width", 32'(rv_o[0]), 32'd0);
    chk("u1 result_valid pulse width", 32'(rv_o[1]), 32'd0);
    for (int h = 0; h < 3; h++) drive(1'b0, 0, 0, 1'b0, 1'b0);
    chk("u0 result count", n_rv[0], n_rv_exp);
    chk("u1 result count", n_rv[1], n_rv_exp);
  endtask

  initial begin
    delta_d[0] = '0;
    delta_d[1] = '0;
    for (int d = 0; d < 2; d++) begin
      e_found[d] = 0; e_cnt[d] = 0; e_xmin[d] = 0; e_xmax[d] = 0; e_ymin[d] = 0; e_ymax[d] = 0;
    end
    repeat (4) drive(1'b0, 0, 0, 1'b0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("u%0d reset result_valid", d), 32'(rv_o[d]), 32'd0);
      chk($sformatf("u%0d reset obj_found", d), 32'(found_o[d]), 32'd0);
      chk($sformatf("u%0d reset pix_count", d), 32'(pix_o[d]), 32'd0);
      chk($sformatf("u%0d reset x_min", d), 32'(xmin_o[d]), 32'd0);
      chk($sformatf("u%0d reset y_center", d), 32'(yc_o[d]), 32'd0);
    end
    aresetn = 1'b1;
    repeat (3) drive(1'b0, 0, 0, 1'b0, 1'b0);

    // First frame after reset carries a block but must not be reported.
    geom(159, 4, 196, 16);
    clear_img(); paint(20, 59, 2, 9);
    run_frame(-1, -1);

    // 20x10 solid block.
    clear_img(); paint(100, 119, 4, 13);
    run_frame(-1, -1);

    // Scattered runs of three: filtered by unit 0, counted by unit 1.
    clear_img();
    paint(10, 12, 1, 1); paint(40, 42, 3, 3); paint(80, 82, 3, 3);
    paint(150, 152, 7, 7); paint(0, 2, 10, 10); paint(157, 159, 15, 15);
    run_frame(-1, -1);

    // 7x7 stays under the pixel gate; 10x10 clears it.
    clear_img(); paint(30, 36, 5, 11);
    run_frame(-1, -1);
    clear_img(); paint(60, 69, 3, 12);
    run_frame(-1, -1);

    // Enable dropped mid-frame, resync, then a normal frame.
    clear_img(); paint(50, 89, 0, 15);
    run_frame(600, 1200);
    clear_img(); paint(5, 24, 6, 15);
    run_frame(-1, -1);
    clear_img(); paint(140, 159, 0, 7);
    run_frame(-1, -1);

    // Continuous video across the 639 -> 0 line wrap.
    geom(639, 0, 10, 8);
    clear_img(); paint(630, 639, 0, 3); paint(0, 9, 1, 6);
    run_frame(-1, -1);

    // Randomized frames.
    geom(159, 4, 196, 16);
    for (int k = 0; k < 6; k++) begin
      int nr;
      clear_img();
      nr = $urandom_range(1, 3);
      for (int i = 0; i < nr; i++) begin
        int w, h, x0, r0;
        w = $urandom_range(1, 30);
        h = $urandom_range(1, 16);
        x0 = $urandom_range(0, 160 - w);
        r0 = $urandom_range(0, 16 - h);
        paint(x0, x0 + w - 1, r0, r0 + h - 1);
      end
      for (int i = 0; i < 6; i++) begin
        int x0;
        x0 = $urandom_range(0, 156);
        paint(x0, x0 + $urandom_range(0, 2), $urandom_range(0, 15), 0 + $urandom_range(0, 15) * 0 + 0);
      end
      run_frame(-1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/object_locator.md
Name: object_locator

Overview:
- Consumer of the binary delta-frame mask stream from the motion-detection stage.
- Scans each frame's mask and locates the moving object as a bounding box: run-length noise rejection, min/max tracking, and a minimum-pixel-count gate.
- Publishes one result per frame at end of frame for the overlay/tracking logic downstream.

Parameters:
- INPUT_WIDTH, 10, width of the delta mask pixel; the mask is all-ones or all-zeros.
- DISP_WIDTH, 11, width of the x/y position counters.
- PIX_DELAY, 1, clocks by which delta_frame lags x_pos/y_pos/is_not_blank; legal range 0..8.
- MIN_RUN, 4, consecutive set pixels in one line required before any pixel counts; range 1..15.
- MIN_PIXELS, 64, qualified pixels per frame required to declare an object.
- CNT_WIDTH, 20, width of the qualified-pixel counter.

Ports:
- clk  in  1  system clock
- aresetn  in  1  asynchronous active-low reset
- enable  in  1  tracking enable; low forces SYNC
- is_not_blank  in  1  active video qualifier, aligned with x_pos/y_pos
- x_pos  in  DISP_WIDTH  current pixel column
- y_pos  in  DISP_WIDTH  current pixel row
- frame_end  in  1  single-cycle pulse from the timing generator, issued in blanking after the last active pixel
- delta_frame  in  INPUT_WIDTH  thresholded delta mask pixel
- obj_found  out  1  last reported frame contained an object
- x_min, x_max, y_min, y_max  out  DISP_WIDTH each  bounding box of the last found object
- x_center, y_center  out  DISP_WIDTH each  (min+max)>>1, computed at DISP_WIDTH+1 bits then truncated
- pix_count  out  CNT_WIDTH  qualified pixel count of the last frame
- result_valid  out  1  one-cycle pulse when the outputs update

Behaviour:
- Alignment: is_not_blank, x_pos and y_pos pass through a PIX_DELAY-stage register line so they align with delta_frame. PIX_DELAY=0 means a direct connection. The delay line resets to 0.
- Mask decode: pixel_on = aligned is_not_blank AND delta_frame[INPUT_WIDTH-1].
- Run counter (4 bits):
  - Clears on a pixel_on=0 cycle and on aligned x_pos==0.
  - Otherwise increments on pixel_on, saturating at MIN_RUN.
  - run_start latches aligned x_pos when a run begins.
- Qualified pixel:
  - pixel_on AND the run count after increment >= MIN_RUN.
  - On the first qualified pixel of a run, the x_min candidate is run_start; on every qualified pixel, the x_max candidate is the current x.
  - y_min/y_max candidates are the current y.
- Accumulators:
  - acc_xmin and acc_ymin reset to all-ones; acc_xmax and acc_ymax reset to 0.
  - acc_cnt saturates at all-ones.
- State machine, reset state SYNC:
  - SYNC: accumulators held cleared. On frame_end with enable=1, go to ACCUM. The partial first frame is discarded.
  - ACCUM: update accumulators on qualified pixels. On frame_end, go to REPORT. If frame_end and a qualified pixel coincide, frame_end wins and the pixel is dropped. enable=0 goes to SYNC with no report.
  - REPORT (exactly one cycle):
    - If acc_cnt >= MIN_PIXELS: latch the bbox and centers, set obj_found=1.
    - Otherwise: obj_found=0 and the bbox/center outputs hold their previous values.
    - In both cases: pix_count = acc_cnt, result_valid=1 on the next cycle, accumulators clear, go to ACCUM. If enable=0, go to SYNC instead.
    - A frame_end arriving during REPORT is ignored.
- Latency: frame_end sampled at edge N gives REPORT after N; outputs and result_valid are asserted after edge N+1, i.e. 2 clocks.
- Reset values: all outputs 0 (obj_found=0, result_valid=0, box 0, pix_count 0). Reset mid-frame abandons the accumulation and returns to SYNC.
- All outputs are registered; nothing combinational reaches an output.

Decomposition:
- Shared package (object_tracking_pkg): state encoding (SYNC/ACCUM/REPORT) and the default DISP_WIDTH/INPUT_WIDTH constants, shared with delta_frame and the overlay block.
- One natural sub-module: pix_align_delay, a parameterised delay line of width DISP_WIDTH*2+1 and depth PIX_DELAY.

Test Plan:
1. Reset, one frame_end, then a frame with a 20x10 solid block at x=100..119, y=200..209, then frame_end -> result_valid 2 clocks later; obj_found=1, x_min=100, x_max=119, y_min=200, y_max=209, x_center=109, y_center=204, pix_count=200.
2. Isolated runs of length 3 with MIN_RUN=4 scattered across a frame -> pix_count=0, obj_found=0, previous box held.
3. A 7x7 block (49 pixels, MIN_RUN=1, MIN_PIXELS=64) -> obj_found=0, pix_count=49; the next frame with a 10x10 block gives obj_found=1 and pix_count=100.
4. First frame after reset containing a block, with no preceding frame_end -> no result_valid for that frame; result reported only for the following frame.
5. enable dropped mid-frame, then raised -> no result_valid for that frame; resync on the next frame_end; the following frame reports correctly.
6. PIX_DELAY=3 with the mask stream delayed 3 clocks, plus a run crossing the line wrap at x=639 to x=0 -> box matches the undelayed golden model; the run counter restarts at x=0.
